// File: rtl/iter_div_pkg.sv
// iter_div_pkg -- shared types for the iterative divider.
//   div_state_t : divider control states (IDLE -> CALC -> DONE).
//   div_op_t    : Execute-side op select (signed/unsigned, quotient/remainder).
package iter_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef enum logic [1:0] {
    Q  = 2'd0,  // signed quotient
    QU = 2'd1,  // unsigned quotient
    R  = 2'd2,  // signed remainder
    RU = 2'd3   // unsigned remainder
  } div_op_t;

endpackage

// File: rtl/iter_div_lzc.sv
// iter_div_lzc -- leading-zero counter over WIDTH bits.
//   value : input vector
//   count : number of leading zeros (WIDTH when value == 0)
module iter_div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             value,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int LW = $clog2(WIDTH + 1);

  // Scan from LSB upward so the highest set bit is the last to win.
  always_comb begin
    count = LW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (value[i]) count = LW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/iter_div.sv
// iter_div -- iterative restoring integer divider for Execute.
//   Retires STEPS quotient bits per CALC cycle; WIDTH must be a multiple
//   of STEPS. Optional early-out (skip leading zeros of |dividend|) is
//   enabled with `define DIV_EARLY_OUT_EN.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   is_flush            abort current op, back to IDLE
//   is_stall            hold result in DONE
//   en                  start request (IDLE only)
//   is_signed           two's complement operands
//   dividend, divisor   operands
//   quotient, remainder registered results, valid while done=1
//   done, busy          result valid / state is CALC
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_flush,
  input  logic             is_stall,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int NCYC = WIDTH / STEPS;
  localparam int CW   = $clog2(NCYC + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, load_cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] abs_a, abs_b, pre_a, r_w, q_w;
  logic [WIDTH:0]   trial;
  logic             q_sign, r_sign, sgn_a, sgn_b, div0, skip;

  assign sgn_a = is_signed & dividend[WIDTH-1];
  assign sgn_b = is_signed & divisor[WIDTH-1];
  assign abs_a = sgn_a ? -dividend : dividend;
  assign abs_b = sgn_b ? -divisor  : divisor;
  assign div0  = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  logic [$clog2(WIDTH+1)-1:0] lz;
  int len, eo_cyc;

  iter_div_lzc #(.WIDTH(WIDTH)) u_lzc (.value(abs_a), .count(lz));

  // Skip is rounded down to whole cycles: the extra leading zeros just
  // produce zero quotient bits, so the result stays exact for any STEPS.
  always_comb begin
    len      = WIDTH - int'(lz);
    eo_cyc   = (len + STEPS - 1) / STEPS;
    load_cnt = CW'(eo_cyc);
    pre_a    = abs_a << (WIDTH - eo_cyc * STEPS);
    skip     = (len == 0);
  end
`else
  assign load_cnt = CW'(NCYC);
  assign pre_a    = abs_a;
  assign skip     = 1'b0;
`endif

  // STEPS shift-subtract steps on {rem, quo}. When the trial difference is
  // negative the shifted-in remainder is below the divisor, so its MSB was
  // zero and dropping it loses nothing.
  always_comb begin
    r_w   = rem_q;
    q_w   = quo_q;
    trial = '0;
    for (int s = 0; s < STEPS; s++) begin
      trial = {r_w, q_w[WIDTH-1]} - {1'b0, dvsr_q};
      if (!trial[WIDTH]) r_w = trial[WIDTH-1:0];
      else               r_w = {r_w[WIDTH-2:0], q_w[WIDTH-1]};
      q_w = {q_w[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  always_comb begin
    state_d = state_q;
    if (is_flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (en) state_d = (div0 || skip) ? DONE : CALC;
        CALC:    if (cnt_q == CW'(1)) state_d = DONE;
        DONE:    if (!is_stall) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
    end else begin
      done <= (state_d == DONE);
      busy <= (state_d == CALC);
      if (is_flush) cnt_q <= '0;
      else begin
        case (state_q)
          IDLE: if (en) begin
            dvsr_q <= abs_b;
            q_sign <= sgn_a ^ sgn_b;
            r_sign <= sgn_a;
            rem_q  <= '0;
            quo_q  <= pre_a;
            cnt_q  <= load_cnt;
            if (div0) begin
              quotient  <= '1;
              remainder <= dividend;
            end else if (skip) begin
              quotient  <= '0;
              remainder <= '0;
            end
          end
          CALC: begin
            rem_q <= r_w;
            quo_q <= q_w;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              quotient  <= q_sign ? -q_w : q_w;
              remainder <= r_sign ? -r_w : r_w;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Parametrised iterative integer divider for the Execute stage, replacing the fixed 32-bit Div unit.
- Supports configurable operand width and 1, 2 or 4 quotient bits retired per cycle.
- Keeps the `en`/`done`/`is_flush`/`is_stall` contract that Execute uses for `eu_stall`.
- Adds defined divide-by-zero and signed-overflow results, plus an optional early-out path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STEPS, minimum 8.
- STEPS, 1, restoring-division steps per CALC cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- is_flush  in  1  abort the current operation and return to IDLE.
- is_stall  in  1  downstream not ready; result is held in DONE.
- en  in  1  start request; sampled only in IDLE.
- is_signed  in  1  operands are two's complement.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- quotient  out  WIDTH  result quotient; valid while done=1.
- remainder  out  WIDTH  result remainder; valid while done=1.
- done  out  1  result valid.
- busy  out  1  state is CALC.

Behaviour:
- Reset (async): state=IDLE; done=0, busy=0, quotient=0, remainder=0; step counter=0.
- All outputs are registered.
- States and transitions: IDLE, CALC, DONE. Priority order, highest first: rst_n, is_flush, then the rules below.
- IDLE:
  - en=1: latch |dividend|, |divisor|, the sign of q (sgn_a^sgn_b), the sign of r (sgn_a) and the original dividend.
  - Absolute values apply only when is_signed=1.
  - divisor==0: go to DONE next cycle.
  - Otherwise load counter=WIDTH/STEPS and go to CALC.
- CALC:
  - Each cycle performs STEPS shift-subtract restoring steps on the {partial remainder, quotient} register.
  - Counter decrements once per cycle; at counter==1, go to DONE.
  - is_stall is ignored in CALC; computation continues.
  - en is ignored; latched operands are used.
- DONE:
  - done=1; quotient and remainder are stable.
  - is_stall=1: hold DONE.
  - is_stall=0: go to IDLE next cycle, with done=0 in that cycle. Execute advances on that same edge, so en drops.
- Latency: en sampled at edge t gives done=1 from edge t+WIDTH/STEPS+1 (33 cycles for 32/1).
- Sign fix-up happens on the CALC->DONE transition:
  - quotient = q_sign ? -q : q.
  - remainder = r_sign ? -r : r.
- Divide by zero (any signedness): quotient = all ones, remainder = dividend unmodified. Done is asserted at t+1.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the unsigned magnitude path, where |MIN| = 2^(WIDTH-1); no special case.
- is_flush in any state: next state IDLE, done=0, busy=0. Quotient and remainder keep their stale values, which are don't-care.
- is_flush with en in the same cycle: flush wins and no operation starts.
- Reset mid-CALC: immediate IDLE; no residual state survives into the next operation.
- en while done=1 in DONE is not a new request; Execute gates en with `~done`.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, compute L = bit length of |dividend| (0 for dividend 0).
  - Pre-shift the dividend by WIDTH-L so that leading zeros are skipped.
  - Load counter=ceil(L/STEPS).
  - L==0 (zero dividend) goes straight to DONE at t+1 with q=0, r=0.
  - Latency is ceil(L/STEPS)+1 cycles.
- Undefined: fixed latency of WIDTH/STEPS+1 cycles in all non-zero-divisor cases. No LZC logic is instantiated.

Decomposition:
- In cpu_defs.svh / shared package:
  - div_state_t enum {IDLE, CALC, DONE}.
  - div_op_t (Q, QU, R, RU), which Execute keeps using for selecting signedness and output.
- One sub-module: iter_div_lzc, a parametrised leading-zero counter over WIDTH bits.
  - Instantiated only under DIV_EARLY_OUT_EN.

Test Plan (WIDTH=32, STEPS=1, macro off unless stated):
1. Unsigned 100/7, en at t → done=1 at t+33 with q=14, r=2. Hold is_stall=1 for 3 cycles → outputs stable and done=1 throughout. Release → done=0 and IDLE next cycle.
2. Signed -7/2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 → q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFF9/2 → q=0x7FFFFFFC, r=1.
3. 0x1234/0, both signed and unsigned → q=0xFFFFFFFF, r=0x1234, done at t+1.
4. Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0, done at t+33.
5. is_flush asserted on CALC cycle 10 → done never asserts, busy=0 next cycle. Then en with 15/3 → q=5, r=0 at full latency. Repeat with rst_n pulsed mid-CALC → same clean restart.
6. STEPS=2 instance: 100/7 → done at t+17. With DIV_EARLY_OUT_EN, STEPS=1: 5/2 → q=2, r=1, done at t+4. 0/9 → q=0, r=0, done at t+1.
